// File: rtl/up_printer_bridge.sv
// Parallel-port (XT5) receiver: captures CPU words on STROBE, buffers the low byte
// in a FIFO and replays it to a Centronics printer with a timed strobe/ACK handshake.
module up_printer_bridge #(
    parameter int DEPTH     = 4,
    parameter int SETUP     = 2,
    parameter int STB_WIDTH = 4,
    parameter int HOLD      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] up_data,
    input  logic        up_strobe,
    input  logic        prn_busy,
    input  logic        prn_nack,
    output logic [7:0]  prn_data,
    output logic        prn_nstrobe,
    output logic [15:0] up_status
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT_ACK
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        ack_seen;

    logic        strobe_s1, strobe_s2, strobe_s3;
    logic        busy_s1, busy_s2;
    logic        nack_s1, nack_s2, nack_s3;
    logic        wr;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr, wptr_nx, rptr_nx;
    logic        full, empty, ovf;
    logic        enq, deq, drop, ctrl;
    logic        unused_bits;

    assign unused_bits = ^up_data[14:8];

    // Synchronizers reset to the lines' idle levels; wr is a registered rising edge of STROBE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_s3 <= 1'b0;
            busy_s1   <= 1'b0;
            busy_s2   <= 1'b0;
            nack_s1   <= 1'b1;
            nack_s2   <= 1'b1;
            nack_s3   <= 1'b1;
            wr        <= 1'b0;
        end else begin
            strobe_s1 <= up_strobe;
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
            busy_s1   <= prn_busy;
            busy_s2   <= busy_s1;
            nack_s1   <= prn_nack;
            nack_s2   <= nack_s1;
            nack_s3   <= nack_s2;
            wr        <= strobe_s2 & ~strobe_s3;
        end
    end

    // A dequeue in the same cycle frees a slot, so a write into a full FIFO still lands.
    always_comb begin
        deq     = (state == ST_IDLE) && !empty && !busy_s2;
        ctrl    = wr && up_data[15];
        enq     = wr && !up_data[15] && (!full || deq);
        drop    = wr && !up_data[15] && full && !deq;
        wptr_nx = enq ? wptr + 1'b1 : wptr;
        rptr_nx = deq ? rptr + 1'b1 : rptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            wptr  <= wptr_nx;
            rptr  <= rptr_nx;
            full  <= (wptr_nx[AW] != rptr_nx[AW]) && (wptr_nx[AW-1:0] == rptr_nx[AW-1:0]);
            empty <= (wptr_nx == rptr_nx);
            if (ctrl)
                ovf <= 1'b0;
            else if (drop)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wptr[AW-1:0]] <= up_data[7:0];
    end

    // Printer handshake; prn_data is loaded only on the IDLE->SETUP transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ack_seen    <= 1'b0;
            prn_data    <= 8'h00;
            prn_nstrobe <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (deq) begin
                        prn_data <= mem[rptr[AW-1:0]];
                        cnt      <= 8'(SETUP - 1);
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == 8'd0) begin
                        prn_nstrobe <= 1'b0;
                        cnt         <= 8'(STB_WIDTH - 1);
                        state       <= ST_PULSE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == 8'd0) begin
                        prn_nstrobe <= 1'b1;
                        cnt         <= 8'(HOLD - 1);
                        state       <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 8'd0) begin
                        ack_seen <= 1'b0;
                        state    <= ST_WAIT_ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!ack_seen) begin
                        if (nack_s3 && !nack_s2)
                            ack_seen <= 1'b1;
                    end else if (nack_s2 && !busy_s2) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign up_status = {12'h000, ovf, busy_s2, empty, full};

endmodule

// File: tb/tb_up_printer_bridge.sv
// Scoreboard bench for up_printer_bridge: a queue-based FIFO model predicts status and
// print order; a monitor pops expected bytes on each printer strobe.
module tb_up_printer_bridge;
    localparam int DEPTH     = 4;
    localparam int SETUP     = 2;
    localparam int STB_WIDTH = 4;
    localparam int HOLD      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] up_data = 16'h0000;
    logic        up_strobe = 1'b0;
    logic        prn_busy = 1'b0;
    logic        prn_nack = 1'b1;
    logic [7:0]  prn_data;
    logic        prn_nstrobe;
    logic [15:0] up_status;

    up_printer_bridge #(.DEPTH(DEPTH), .SETUP(SETUP), .STB_WIDTH(STB_WIDTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .up_data(up_data), .up_strobe(up_strobe),
        .prn_busy(prn_busy), .prn_nack(prn_nack), .prn_data(prn_data),
        .prn_nstrobe(prn_nstrobe), .up_status(up_status)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         print_cnt = 0;
    bit         mon_en = 1'b0;
    bit         mdl_ovf = 1'b0;
    logic [7:0] exp_q[$];
    logic       mon_prev;
    int         mon_low;
    logic [7:0] mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_status();
        return {12'h000, mdl_ovf, prn_busy, exp_q.size() == 0, exp_q.size() == DEPTH};
    endfunction

    // Reference behaviour of a CPU write while nothing is being dequeued.
    task automatic model_write(input logic [15:0] w);
        if (w[15])
            mdl_ovf = 1'b0;
        else if (exp_q.size() < DEPTH)
            exp_q.push_back(w[7:0]);
        else
            mdl_ovf = 1'b1;
    endtask

    task automatic pulse_strobe(input logic [15:0] w, input int width);
        up_data   = w;
        up_strobe = 1'b1;
        tick(width);
        up_strobe = 1'b0;
    endtask

    task automatic busy_write(input logic [15:0] w);
        pulse_strobe(w, 1);
        tick(5);
        model_write(w);
        check("status_after_write", up_status, exp_status());
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick(1);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes still pending after %0d cycles, expected 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
        tick(20);
    endtask

    // Printer: returns ACK three cycles after the strobe rises.
    initial begin
        forever begin
            @(posedge prn_nstrobe);
            if (!rst) begin
                repeat (3) @(posedge clk);
                #1 prn_nack = 1'b0;
                repeat (2) @(posedge clk);
                #1 prn_nack = 1'b1;
            end
        end
    end

    // Monitor: each strobe fall must carry the next expected byte for STB_WIDTH cycles.
    initial begin
        mon_prev = 1'b1;
        mon_low  = 0;
        mon_d    = 8'h00;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                mon_prev = 1'b1;
                mon_low  = 0;
            end else begin
                if (mon_prev && !prn_nstrobe) begin
                    mon_low = 1;
                    mon_d   = prn_data;
                    print_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_print: got byte 0x%02h, expected no print", prn_data);
                    end else begin
                        check("print_data", {24'h0, prn_data}, {24'h0, exp_q.pop_front()});
                    end
                end else if (!prn_nstrobe) begin
                    mon_low++;
                end else if (!mon_prev) begin
                    check("strobe_width", mon_low, STB_WIDTH);
                    check("data_stable", {24'h0, prn_data}, {24'h0, mon_d});
                end
                mon_prev = prn_nstrobe;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        int          pc;
        int          k;

        // Reset
        tick(3);
        check("reset_status", up_status, 16'h0002);
        check("reset_data", {24'h0, prn_data}, 32'h0);
        check("reset_nstrobe", prn_nstrobe, 1);
        rst = 1'b0;
        tick(3);
        mon_en = 1'b1;

        // Single write with exact latency
        exp_q.push_back(8'h41);
        up_data   = 16'h0041;
        up_strobe = 1'b1;
        tick(1);
        up_strobe = 1'b0;
        tick(3);
        check("single_status_enq", up_status, 16'h0000);
        check("single_data_before", {24'h0, prn_data}, 32'h0);
        tick(1);
        check("single_data_loaded", {24'h0, prn_data}, 32'h41);
        check("single_status_deq", up_status, 16'h0002);
        check("single_setup_hi0", prn_nstrobe, 1);
        tick(1);
        check("single_setup_hi1", prn_nstrobe, 1);
        tick(1);
        check("single_strobe_fall", prn_nstrobe, 0);
        wait_drain(100);

        // Fill, overflow, control clear
        prn_busy = 1'b1;
        tick(4);
        for (int i = 1; i <= 5; i++) busy_write(16'(i));
        check("fill_overflow_status", up_status, 16'h000D);
        pc = print_cnt;
        busy_write(16'h8000);
        check("ctrl_clear_status", up_status, 16'h0005);
        tick(10);
        check("ctrl_no_print", print_cnt, pc);

        // Enqueue aligned with the first dequeue while full
        up_data   = 16'h0006;
        up_strobe = 1'b1;
        tick(1);
        up_strobe = 1'b0;
        prn_busy  = 1'b0;
        tick(3);
        exp_q.push_back(8'h06);
        check("simul_full_status", up_status, 16'h0001);
        check("simul_deq_data", {24'h0, prn_data}, 32'h01);
        wait_drain(400);

        // Strobe width: one wide pulse counts once, two spaced pulses count twice
        prn_busy = 1'b1;
        tick(4);
        busy_write(16'h0011);
        pulse_strobe(16'h0055, 10);
        tick(6);
        model_write(16'h0055);
        check("wide_strobe_status", up_status, exp_status());
        up_data   = 16'h0033;
        up_strobe = 1'b1;
        tick(1);
        up_strobe = 1'b0;
        tick(2);
        up_strobe = 1'b1;
        tick(1);
        up_strobe = 1'b0;
        tick(6);
        model_write(16'h0033);
        model_write(16'h0033);
        check("two_pulse_status", up_status, 16'h0005);
        prn_busy = 1'b0;
        wait_drain(400);

        // Randomized bursts against the model
        for (int r = 0; r < 8; r++) begin
            prn_busy = 1'b1;
            tick(4);
            for (int j = 0; j < int'($urandom_range(1, 7)); j++) begin
                w = 16'($urandom);
                w[15] = ($urandom_range(0, 4) == 0);
                busy_write(w);
            end
            prn_busy = 1'b0;
            wait_drain(60 * DEPTH + 100);
        end

        // Reset in the middle of a strobe pulse with data still queued
        exp_q.push_back(8'h21);
        pulse_strobe(16'h0021, 1);
        tick(3);
        pulse_strobe(16'h0022, 1);
        tick(3);
        pulse_strobe(16'h0023, 1);
        k = 0;
        while (prn_nstrobe && k < 50) begin
            tick(1);
            k++;
        end
        check("reach_pulse", prn_nstrobe, 0);
        tick(1);
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        check("reset_async_nstrobe", prn_nstrobe, 1);
        exp_q.delete();
        mdl_ovf = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("post_reset_status", up_status, 16'h0002);
        check("post_reset_data", {24'h0, prn_data}, 32'h0);
        mon_en = 1'b1;
        pc = print_cnt;
        tick(60);
        check("post_reset_no_print", print_cnt, pc);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/up_printer_bridge.md
# up_printer_bridge

Receiver stage on the XT5 parallel-port (УП) connector of the BK-0011M model. It captures 16-bit words written by the CPU to the УП output register, qualified by that register's STROBE pulse, and queues them in a small FIFO. It replays the low byte of each word to a Centronics-style printer with a timed strobe/ACK handshake. Status flows back to the CPU through the УП input pins: FIFO full/empty, printer busy and a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, 2..16.
- `SETUP`, 2 — clk cycles `prn_data` is stable before `prn_nstrobe` falls.
- `STB_WIDTH`, 4 — clk cycles `prn_nstrobe` stays low.
- `HOLD`, 2 — clk cycles `prn_data` is held after `prn_nstrobe` rises.

Ports:
- `clk` in 1 — system clock, nominal 250 ns period.
- `rst` in 1 — asynchronous, active-high reset.
- `up_data` in 16 — XT5 output pins (УП output register contents).
- `up_strobe` in 1 — STROBE from the УП write path; asynchronous to `clk`, active high, ≥1 clk wide.
- `prn_busy` in 1 — printer BUSY, active high; asynchronous.
- `prn_nack` in 1 — printer ACK, active low; asynchronous.
- `prn_data` out 8 — printer data bus.
- `prn_nstrobe` out 1 — printer strobe, active low.
- `up_status` out 16 — to XT5 input pins:
  - bit0: FIFO full.
  - bit1: FIFO empty.
  - bit2: synchronized `prn_busy`.
  - bit3: overflow (sticky).
  - bits 15..4: 0.

## Operation
- **Input synchronizers.** `up_strobe`, `prn_busy` and `prn_nack` each pass through 2-FF synchronizers. A rising-edge detect on synced `up_strobe` produces a one-cycle `wr`.
- **Write capture.** On `wr`, `up_data` is sampled directly; the УП output register holds it stable until the next write.
  - If bit15 = 1, the word is a control word: it clears overflow and is not enqueued.
  - If bit15 = 0 and the FIFO is not full, `up_data[7:0]` is enqueued.
  - If bit15 = 0 and the FIFO is full, the word is dropped, overflow is set, and FIFO contents are unchanged.
- **FIFO.** `DEPTH` x 8 bits. Read/write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH; the MSB distinguishes full from empty. Enqueue and dequeue in the same cycle are both honoured, with count unchanged, including when full (the dequeue frees the slot first).
- **Printer FSM:**
  - IDLE: when FIFO is non-empty and synced busy = 0, dequeue into the `prn_data` register and go to SETUP.
  - SETUP: wait `SETUP` cycles, then go to PULSE.
  - PULSE: `prn_nstrobe` = 0 for `STB_WIDTH` cycles, then go to HOLD.
  - HOLD: `prn_nstrobe` = 1, wait `HOLD` cycles, then go to WAIT_ACK.
  - WAIT_ACK: wait for a synced `prn_nack` falling edge, then for synced `prn_nack` = 1 and synced busy = 0, then go to IDLE.
- `prn_data` changes only on the IDLE→SETUP transition.
- **Reset values:**
  - FSM = IDLE, FIFO empty, overflow = 0.
  - `prn_data` = 8'h00, `prn_nstrobe` = 1.
  - `up_status` = 16'h0002.
  - Synchronizer flops reset to their idle levels: strobe 0, busy 0, nack 1.
- **Reset mid-operation.** Any active strobe is aborted at once (`prn_nstrobe` goes high asynchronously) and queued data is discarded.

## Timing
- **Write latency.** A `up_strobe` rise sampled at clk edge N gives `wr` at edge N+2, and the FIFO/status update is visible after edge N+3. Status bits are registered.
- **Strobe spacing.** Back-to-back strobes need ≥2 clk low between pulses to register as separate writes. A strobe held high across many cycles counts as one write.
- **Print latency.** With an empty FIFO and an idle printer, `prn_data` updates 1 cycle after the enqueue becomes visible. `prn_nstrobe` then falls `SETUP` cycles later, stays low `STB_WIDTH` cycles, and is followed by `HOLD` cycles.
- **Throughput.** The minimum per-byte period is 1 + `SETUP` + `STB_WIDTH` + `HOLD` + ACK time + 2-cycle synchronizer delay.
- **Busy during IDLE.** While synced busy = 1, no dequeue occurs. A busy rising during SETUP/PULSE/HOLD does not abort the current byte.
- **Missing ACK.** WAIT_ACK has no timeout; the FSM waits indefinitely.

## Test plan
- **Reset:** assert `rst` with the FSM mid-PULSE → `prn_nstrobe` = 1 immediately, `up_status` = 16'h0002 and `prn_data` = 8'h00 after release.
- **Single write:** write 16'h0041 with the printer idle and ACK returned 3 cycles after `prn_nstrobe` rises →
  - `prn_data` = 8'h41;
  - `prn_nstrobe` low for exactly 4 cycles, starting 2 cycles after `prn_data` changes;
  - status 16'h0002 → 16'h0000 → 16'h0002.
- **Fill and overflow:** hold `prn_busy` = 1 and write 5 data words 8'h01..8'h05 → after the 4th, status = 16'h0005; after the 5th, status = 16'h000D (overflow set, 8'h05 dropped); release busy → bytes 01, 02, 03, 04 printed in order.
- **Control clear:** after the overflow above, write 16'h8000 → bit3 clears; FIFO count is unchanged and nothing is printed.
- **Simultaneous enqueue/dequeue:** with the FIFO full, align a `wr` with the IDLE dequeue cycle → both take effect, full stays 1, and the new byte is printed last.
- **Strobe width:** a single 10-cycle-wide `up_strobe` enqueues exactly one word; two 1-cycle pulses separated by 2 low cycles enqueue two.
